// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS stopwatch.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ADJ   = 2'd3
    } timer_state_t;

    // Code the display stage shows as a dark digit
    localparam logic [3:0] BLANK_DIGIT    = 4'hF;
    localparam logic [3:0] DIGIT_MAX_ONES = 4'd9;
    localparam logic [3:0] DIGIT_MAX_TENS = 4'd5;

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD counter 00..59 with synchronous clear; one per time field.
module bcd_mod60
    import timer_pkg::*;
(
    input  logic       clk_dv,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       carry
);

    logic ones_max;
    logic tens_max;

    assign ones_max = (ones == DIGIT_MAX_ONES);
    assign tens_max = (tens == DIGIT_MAX_TENS);

    // Carry out of the field: an increment arriving while the field reads 59
    assign carry = inc && ones_max && tens_max;

    // Digit registers; clear wins over increment
    always_ff @(posedge clk_dv or posedge reset) begin
        if (reset) begin
            ones <= '0;
            tens <= '0;
        end else if (clr) begin
            ones <= '0;
            tens <= '0;
        end else if (inc) begin
            if (ones_max) begin
                ones <= '0;
                tens <= tens_max ? 4'd0 : tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_mmss_timer.sv
// MM:SS stopwatch: run/pause/clear/adjust FSM, one-second prescaler,
// adjust-mode blink and BCD digit outputs for the anode-cycling display.
module bcd_mmss_timer
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 100,
    parameter int unsigned BLINK_DIV = 50
) (
    input  logic       clk_dv,
    input  logic       reset,
    input  logic       btn_run,
    input  logic       btn_clr,
    input  logic       adj_en,
    input  logic       adj_sel,
    input  logic       adj_inc,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic       running,
    output logic       wrap
);

    localparam int TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    timer_state_t  state, state_nx;

    logic          run_q, clr_q, inc_q;
    logic          run_ev, clr_ev, inc_ev;

    logic [TW-1:0] presc, presc_nx;
    logic [BW-1:0] blink_cnt, blink_nx;
    logic          phase, phase_nx;
    logic          blank_sec, blank_min;

    logic          tick;
    logic          sec_inc, min_inc;
    logic          sec_carry, min_carry;
    logic          wrap_nx;
    logic [3:0]    s_ones, s_tens, m_ones, m_tens;

    // Edge-detector history; resets high so a level held through reset is no event
    always_ff @(posedge clk_dv or posedge reset) begin
        if (reset) begin
            run_q <= 1'b1;
            clr_q <= 1'b1;
            inc_q <= 1'b1;
        end else begin
            run_q <= btn_run;
            clr_q <= btn_clr;
            inc_q <= adj_inc;
        end
    end

    assign run_ev = btn_run & ~run_q;
    assign clr_ev = btn_clr & ~clr_q;
    assign inc_ev = adj_inc & ~inc_q;

    // One-second tick only exists while running
    assign tick = (state == RUN) && (presc == TICK_LAST);

    // Seconds advance on tick or a manual bump; minutes take the seconds carry
    // only while running, so adjusting never carries between fields
    assign sec_inc = tick || ((state == ADJ) && inc_ev && !adj_sel);
    assign min_inc = ((state == RUN) && sec_carry) ||
                     ((state == ADJ) && inc_ev && adj_sel);

    bcd_mod60 u_sec (
        .clk_dv (clk_dv),
        .reset  (reset),
        .inc    (sec_inc),
        .clr    (clr_ev),
        .ones   (s_ones),
        .tens   (s_tens),
        .carry  (sec_carry)
    );

    bcd_mod60 u_min (
        .clk_dv (clk_dv),
        .reset  (reset),
        .inc    (min_inc),
        .clr    (clr_ev),
        .ones   (m_ones),
        .tens   (m_tens),
        .carry  (min_carry)
    );

    // State register
    always_ff @(posedge clk_dv or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state; clear overrides every other event
    always_comb begin
        state_nx = state;
        if (clr_ev) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (run_ev)      state_nx = RUN;
                    else if (adj_en) state_nx = ADJ;
                end
                RUN: begin
                    if (run_ev)      state_nx = PAUSE;
                end
                PAUSE: begin
                    if (run_ev)      state_nx = RUN;
                    else if (adj_en) state_nx = ADJ;
                end
                ADJ: begin
                    if (!adj_en)     state_nx = PAUSE;
                end
                default:             state_nx = IDLE;
            endcase
        end
    end

    // Prescaler and blink next values; pause keeps the partial second
    always_comb begin
        presc_nx = presc;
        blink_nx = '0;
        phase_nx = 1'b0;
        if (clr_ev) begin
            presc_nx = '0;
        end else begin
            if (state == RUN)
                presc_nx = tick ? '0 : presc + TW'(1);
            else if ((state == ADJ) && !adj_en)
                presc_nx = '0;

            // Blink restarts in the dark phase each time adjust is entered
            if (state == ADJ) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_nx = '0;
                    phase_nx = ~phase;
                end else begin
                    blink_nx = blink_cnt + BW'(1);
                    phase_nx = phase;
                end
            end
        end
    end

    // Only a 59:59 -> 00:00 rollover in RUN counts as a wrap
    assign wrap_nx = (state == RUN) && min_carry && !clr_ev;

    // Prescaler, blink, blanking selects and status outputs
    always_ff @(posedge clk_dv or posedge reset) begin
        if (reset) begin
            presc     <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
            blank_sec <= 1'b0;
            blank_min <= 1'b0;
            running   <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            presc     <= presc_nx;
            blink_cnt <= blink_nx;
            phase     <= phase_nx;
            blank_sec <= (state_nx == ADJ) && !phase_nx && !adj_sel;
            blank_min <= (state_nx == ADJ) && !phase_nx &&  adj_sel;
            running   <= (state_nx == RUN);
            wrap      <= wrap_nx;
        end
    end

    // Blanking mux: both data and select come straight from flops
    assign d0 = blank_sec ? BLANK_DIGIT : s_ones;
    assign d1 = blank_sec ? BLANK_DIGIT : s_tens;
    assign d2 = blank_min ? BLANK_DIGIT : m_ones;
    assign d3 = blank_min ? BLANK_DIGIT : m_tens;

endmodule

// File: tb/tb_bcd_mmss_timer.sv
// Self-checking bench for bcd_mmss_timer with TICK_DIV=4, BLINK_DIV=3.
module tb_bcd_mmss_timer;

    localparam int TICK_DIV  = 4;
    localparam int BLINK_DIV = 3;

    logic       clk_dv = 1'b0;
    logic       reset;
    logic       btn_run, btn_clr, adj_en, adj_sel, adj_inc;
    logic [3:0] d0, d1, d2, d3;
    logic       running, wrap;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        run, clr, aen, asel, ainc;
        logic [15:0] d;
        logic        rng, wrp;
    } vec_t;

    typedef struct {
        string       nm;
        logic [15:0] d;
        logic        rng, wrp;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[12];

    bcd_mmss_timer #(.TICK_DIV(TICK_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clk_dv  (clk_dv),
        .reset   (reset),
        .btn_run (btn_run),
        .btn_clr (btn_clr),
        .adj_en  (adj_en),
        .adj_sel (adj_sel),
        .adj_inc (adj_inc),
        .d0      (d0),
        .d1      (d1),
        .d2      (d2),
        .d3      (d3),
        .running (running),
        .wrap    (wrap)
    );

    always #5 clk_dv = ~clk_dv;

    function automatic vec_t mk(logic run, logic clr, logic aen, logic asel, logic ainc,
                                logic [15:0] d, logic rng, logic wrp);
        vec_t v;
        v.run = run; v.clr = clr; v.aen = aen; v.asel = asel; v.ainc = ainc;
        v.d = d; v.rng = rng; v.wrp = wrp;
        return v;
    endfunction

    function automatic logic [7:0] bcd(int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic check(string nm, logic [15:0] ed, logic er, logic ew);
        logic [15:0] ad;
        ad = {d3, d2, d1, d0};
        checks++;
        if (ad !== ed || running !== er || wrap !== ew) begin
            failures++;
            $display("FAIL %s: got d3..d0=%h running=%b wrap=%b, want d3..d0=%h running=%b wrap=%b",
                     nm, ad, running, wrap, ed, er, ew);
        end
    endtask

    // Drive inputs at the falling edge, queue the expectation, compare one cycle later
    task automatic apply(string nm, vec_t v);
        exp_t e;
        btn_run = v.run; btn_clr = v.clr; adj_en = v.aen; adj_sel = v.asel; adj_inc = v.ainc;
        e.nm = nm; e.d = v.d; e.rng = v.rng; e.wrp = v.wrp;
        exp_q.push_back(e);
        @(posedge clk_dv);
        @(negedge clk_dv);
        e = exp_q.pop_front();
        check(e.nm, e.d, e.rng, e.wrp);
    endtask

    // Unchecked cycle
    task automatic cyc(logic run, logic clr, logic aen, logic asel, logic ainc);
        btn_run = run; btn_clr = clr; adj_en = aen; adj_sel = asel; adj_inc = ainc;
        @(posedge clk_dv);
        @(negedge clk_dv);
    endtask

    // Load a time via adjust mode from IDLE/PAUSE, ending in PAUSE
    task automatic adj_load(int s, int m);
        cyc(0, 0, 1, 0, 0);
        repeat (s) begin cyc(0, 0, 1, 0, 1); cyc(0, 0, 1, 0, 0); end
        cyc(0, 0, 1, 1, 0);
        repeat (m) begin cyc(0, 0, 1, 1, 1); cyc(0, 0, 1, 1, 0); end
        apply("adj_exit", mk(0, 0, 0, 1, 0, {bcd(m), bcd(s)}, 0, 0));
    endtask

    task automatic do_clr();
        apply("clear", mk(0, 1, 0, 0, 0, 16'h0000, 0, 0));
        cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        int m;
        int k;
        logic blank;

        // Count from reset: first increment 4 cycles after RUN, then every 4
        tbl[0]  = mk(1, 0, 0, 0, 0, 16'h0000, 1, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 16'h0000, 1, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 16'h0000, 1, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 16'h0000, 1, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 16'h0001, 1, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 16'h0001, 1, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 16'h0001, 1, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 16'h0001, 1, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 16'h0002, 1, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 16'h0002, 1, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 16'h0002, 1, 0);
        // run edge sampled with prescaler at 2 -> PAUSE
        tbl[11] = mk(1, 0, 0, 0, 0, 16'h0002, 0, 0);

        reset = 1'b1;
        btn_run = 0; btn_clr = 0; adj_en = 0; adj_sel = 0; adj_inc = 0;
        repeat (2) @(negedge clk_dv);
        check("reset_state", 16'h0000, 0, 0);
        reset = 1'b0;
        apply("idle", mk(0, 0, 0, 0, 0, 16'h0000, 0, 0));

        for (int i = 0; i < 12; i++)
            apply($sformatf("vec%0d", i), tbl[i]);

        // Paused 20 cycles; adj_inc edges outside ADJ must be ignored
        for (int i = 0; i < 20; i++)
            apply("paused_hold", mk(0, 0, 0, 0, logic'((i / 2) % 2), 16'h0002, 0, 0));
        apply("resume", mk(1, 0, 0, 0, 0, 16'h0002, 1, 0));
        apply("resume_inc", mk(0, 0, 0, 0, 0, 16'h0003, 1, 0));
        do_clr();

        // Clear in the same cycle as a tick at 12:34
        adj_load(34, 12);
        apply("run_1234", mk(1, 0, 0, 0, 0, 16'h1234, 1, 0));
        repeat (3) apply("run_1234", mk(0, 0, 0, 0, 0, 16'h1234, 1, 0));
        apply("clr_on_tick", mk(0, 1, 0, 0, 0, 16'h0000, 0, 0));
        repeat (4) apply("idle_after_clr", mk(0, 0, 0, 0, 0, 16'h0000, 0, 0));

        // 59:58 -> 59:59 -> 00:00 with a one-cycle wrap pulse
        adj_load(58, 59);
        apply("run_5958", mk(1, 0, 0, 0, 0, 16'h5958, 1, 0));
        for (int j = 1; j <= 9; j++)
            apply($sformatf("wrap_k%0d", j),
                  mk(0, 0, 0, 0, 0, (j < 4) ? 16'h5958 : (j < 8) ? 16'h5959 : 16'h0000,
                     1, logic'(j == 8)));
        apply("pause_after_wrap", mk(1, 0, 0, 0, 0, 16'h0000, 0, 0));
        cyc(0, 0, 0, 0, 0);
        do_clr();

        // Minutes adjust with blink: 61 edges -> 01, seconds stay 07 and never blank
        adj_load(7, 0);
        k = 0;
        apply("adj_enter", mk(0, 0, 1, 1, 0, 16'hFF07, 0, 0));
        m = 0;
        for (int i = 0; i < 61; i++) begin
            for (int h = 0; h < 2; h++) begin
                k++;
                if (h == 0) m = (m + 1) % 60;
                blank = (((k / BLINK_DIV) % 2) == 0);
                apply("adj_blink",
                      mk(0, 0, 1, 1, logic'(h == 0),
                         blank ? 16'hFF07 : {bcd(m), 8'h07}, 0, 0));
            end
        end
        apply("adj_done", mk(0, 0, 0, 1, 0, 16'h0107, 0, 0));
        do_clr();

        // Asynchronous reset mid-RUN with btn_run held
        apply("run_hold", mk(1, 0, 0, 0, 0, 16'h0000, 1, 0));
        for (int j = 1; j <= 4; j++)
            apply("run_hold", mk(1, 0, 0, 0, 0, (j < 4) ? 16'h0000 : 16'h0001, 1, 0));
        #1 reset = 1'b1;
        #1 check("async_reset", 16'h0000, 0, 0);
        repeat (2) @(negedge clk_dv);
        reset = 1'b0;
        repeat (6) apply("held_no_event", mk(1, 0, 0, 0, 0, 16'h0000, 0, 0));
        apply("run_release", mk(0, 0, 0, 0, 0, 16'h0000, 0, 0));
        apply("run_after_reset", mk(1, 0, 0, 0, 0, 16'h0000, 1, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
